// File: rtl/main_mem_burst.sv
// Byte-addressable RAM at START_ADDRESS with single and 4/8/16-word burst accesses,
// big-endian word port and programmable read latency. Range checking: MAIN_MEM_ADDR_CHECK_EN.
module main_mem_burst #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int MEM_SIZE     = 1048576,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000,
  parameter int READ_LATENCY = 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wren,
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic [2:0]              acc_size,
  input  logic [DATA_SIZE-1:0]    d_in,
  output logic [DATA_SIZE-1:0]    d_out,
  output logic                    d_valid,
  output logic                    busy,
  output logic                    err
);
  localparam int IW      = $clog2(MEM_SIZE);
  localparam int RL_WAIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

  function automatic logic [4:0] beats_of(input logic [2:0] sz);
    case (sz)
      3'b011:  return 5'd4;
      3'b100:  return 5'd8;
      3'b101:  return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [ADDRESS_SIZE-1:0] align_idx(input logic [2:0] sz,
                                                        input logic [ADDRESS_SIZE-1:0] a);
    case (sz)
      3'b000:  return a;
      3'b001:  return {a[ADDRESS_SIZE-1:1], 1'b0};
      default: return {a[ADDRESS_SIZE-1:2], 2'b00};
    endcase
  endfunction

  logic [7:0] mem [MEM_SIZE];

  state_t                  state, next_state;
  logic [ADDRESS_SIZE-1:0] base_q, cur_idx;
  logic [2:0]              size_q, cur_size;
  logic [4:0]              beat_q, nbeats;
  logic [2:0]              wait_q;
  logic                    accept, last_beat, do_write, beat_ok;
  logic [IW-1:0]           i0, i1, i2, i3;
  logic [DATA_SIZE-1:0]    rd_word;

  // The accepting edge uses the live request; later beats walk from the latched base.
  assign accept    = rst_n && enable && (state == IDLE);
  assign cur_size  = accept ? acc_size : size_q;
  assign cur_idx   = accept ? align_idx(acc_size, addr - START_ADDRESS)
                            : base_q + {{(ADDRESS_SIZE-7){1'b0}}, beat_q, 2'b00};
  assign nbeats    = beats_of(size_q);
  assign last_beat = (beat_q == nbeats - 5'd1);
  assign i0 = cur_idx[IW-1:0];
  assign i1 = i0 + IW'(1);
  assign i2 = i0 + IW'(2);
  assign i3 = i0 + IW'(3);

`ifdef MAIN_MEM_ADDR_CHECK_EN
  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE+1)'(MEM_SIZE);
  logic                  under_q, cur_under, err_q;
  logic [ADDRESS_SIZE:0] span_end;

  assign cur_under = accept ? (addr < START_ADDRESS) : under_q;
  assign span_end  = {1'b0, cur_idx} + ((cur_size == 3'b000) ? (ADDRESS_SIZE+1)'(0) :
                                        (cur_size == 3'b001) ? (ADDRESS_SIZE+1)'(1) :
                                                               (ADDRESS_SIZE+1)'(3));
  assign beat_ok   = !cur_under && (span_end < MEM_LIMIT);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      under_q <= 1'b0;
    end else if (accept) begin
      err_q   <= wren && !beat_ok;
      under_q <= cur_under;
    end else if ((state == RD_BURST || state == WR_BURST) && !beat_ok) begin
      err_q   <= 1'b1;
    end
  end
`else
  assign beat_ok = 1'b1;
  assign err     = 1'b0;
`endif

  assign do_write = rst_n && beat_ok && ((accept && wren) || state == WR_BURST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (accept) begin
          if (wren) next_state = (beats_of(acc_size) > 5'd1) ? WR_BURST : IDLE;
          else      next_state = (READ_LATENCY > 1) ? RD_WAIT : RD_BURST;
        end
      RD_WAIT:            if (wait_q == 3'd0) next_state = RD_BURST;
      RD_BURST, WR_BURST: if (last_beat)      next_state = IDLE;
      default:            next_state = IDLE;
    endcase
  end

  // busy covers the cycle the last read beat is presented, after the FSM is already idle.
  always_comb busy = (state != IDLE) || d_valid;

  always_comb begin
    case (cur_size)
      3'b000:  rd_word = {24'd0, mem[i0]};
      3'b001:  rd_word = {16'd0, mem[i0], mem[i1]};
      default: rd_word = {mem[i0], mem[i1], mem[i2], mem[i3]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_out   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      size_q  <= '0;
    end else begin
      d_valid <= (state == RD_BURST);
      if (state == RD_BURST) d_out <= beat_ok ? rd_word : '0;
      if (accept) begin
        base_q <= cur_idx;
        size_q <= acc_size;
        beat_q <= wren ? 5'd1 : 5'd0;
        wait_q <= 3'(RL_WAIT);
      end else if (state == RD_BURST || state == WR_BURST) begin
        beat_q <= beat_q + 5'd1;
      end else if (state == RD_WAIT) begin
        wait_q <= wait_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      case (cur_size)
        3'b000: mem[i0] <= d_in[7:0];
        3'b001: begin
          mem[i0] <= d_in[15:8];
          mem[i1] <= d_in[7:0];
        end
        default: begin
          mem[i0] <= d_in[31:24];
          mem[i1] <= d_in[23:16];
          mem[i2] <= d_in[15:8];
          mem[i3] <= d_in[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_main_mem_burst.sv
// Bench for main_mem_burst: two instances (READ_LATENCY 1 and 3) share stimulus and are
// compared cycle by cycle against a byte-array model of the first 256 bytes of RAM.
module tb_main_mem_burst;
  localparam logic [31:0] START = 32'h80020000;

  logic        clk, rst_n, enable, wren;
  logic [31:0] addr, d_in;
  logic [2:0]  acc_size;
  logic [31:0] d_out1, d_out3;
  logic        d_valid1, d_valid3, busy1, busy3, err1, err3;

  main_mem_burst #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wren(wren), .addr(addr),
    .acc_size(acc_size), .d_in(d_in), .d_out(d_out1), .d_valid(d_valid1),
    .busy(busy1), .err(err1));
  main_mem_burst #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wren(wren), .addr(addr),
    .acc_size(acc_size), .d_in(d_in), .d_out(d_out3), .d_valid(d_valid3),
    .busy(busy3), .err(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [7:0]  mm [256];
  logic [31:0] wbuf [16];
  logic [31:0] rb [2][16];
  logic [31:0] lastd [2];

  typedef struct {
    bit        wr;
    bit [31:0] a;
    bit [2:0]  sz;
    bit [31:0] w;
    bit [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic int nbeats(input bit [2:0] sz);
    case (sz)
      3'd3: return 4;
      3'd4: return 8;
      3'd5: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int algn(input bit [2:0] sz, input int off);
    if (sz == 3'd0) return off;
    if (sz == 3'd1) return off - (off % 2);
    return off - (off % 4);
  endfunction

  function automatic logic [31:0] beat_word(input int idx, input bit [2:0] sz, input int i);
    int b = idx + 4 * i;
    if (sz == 3'd0) return {24'd0, mm[b]};
    if (sz == 3'd1) return {16'd0, mm[b], mm[b+1]};
    return {mm[b], mm[b+1], mm[b+2], mm[b+3]};
  endfunction

  task automatic model_write(input int idx, input bit [2:0] sz, input int n);
    for (int i = 0; i < n; i++) begin
      int b = idx + 4 * i;
      if (sz == 3'd0) mm[b] = wbuf[i][7:0];
      else if (sz == 3'd1) begin
        mm[b] = wbuf[i][15:8]; mm[b+1] = wbuf[i][7:0];
      end else begin
        mm[b] = wbuf[i][31:24]; mm[b+1] = wbuf[i][23:16];
        mm[b+2] = wbuf[i][15:8]; mm[b+3] = wbuf[i][7:0];
      end
    end
  endtask

  task automatic chk_cycle(input int lat, input bit wr, input int n, input int k,
                           input int idx, input bit [2:0] sz);
    int j = (lat == 1) ? 0 : 1;
    logic dv, bz, er;
    logic [31:0] dq, ed;
    bit ev, eb;
    dv = j ? d_valid3 : d_valid1;
    bz = j ? busy3 : busy1;
    er = j ? err3 : err1;
    dq = j ? d_out3 : d_out1;
    ev = !wr && k >= lat && k < lat + n;
    eb = wr ? (k < n - 1) : (k < lat + n);
    if (ev) begin
      ed = beat_word(idx, sz, k - lat);
      lastd[j] = ed;
      rb[j][k-lat] = dq;
    end else ed = lastd[j];
    chk($sformatf("L%0d busy k%0d", lat, k), {31'd0, bz}, {31'd0, eb});
    chk($sformatf("L%0d d_valid k%0d", lat, k), {31'd0, dv}, {31'd0, ev});
    chk($sformatf("L%0d d_out k%0d", lat, k), dq, ed);
    chk($sformatf("L%0d err k%0d", lat, k), {31'd0, er}, 32'd0);
  endtask

  // One request, run until both instances are idle; noise pulses enable while busy.
  task automatic xact(input bit wr, input bit [31:0] a, input bit [2:0] sz, input bit noise);
    int n = nbeats(sz);
    int idx = algn(sz, int'(a - START));
    int last = wr ? n - 1 : 3 + n;
    int nlim = wr ? n - 1 : n;
    if (wr) model_write(idx, sz, n);
    enable = 1'b1; wren = wr; addr = a; acc_size = sz; d_in = wbuf[0];
    for (int k = 0; k <= last; k++) begin
      tick();
      enable = 1'b0;
      d_in = (wr && k + 1 < n) ? wbuf[k+1] : $urandom;
      if (noise && k + 1 <= nlim) begin
        enable = 1'b1; wren = 1'($urandom); addr = $urandom; acc_size = 3'($urandom);
      end
      chk_cycle(1, wr, n, k, idx, sz);
      chk_cycle(3, wr, n, k, idx, sz);
    end
    enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wren = 1'b0; addr = '0; acc_size = '0; d_in = '0;
    lastd[0] = '0; lastd[1] = '0;
    for (int i = 0; i < 256; i++) mm[i] = 8'd0;
    tick(); tick();
    chk("rst busy", {30'd0, busy1, busy3}, 32'd0);
    chk("rst d_valid", {30'd0, d_valid1, d_valid3}, 32'd0);
    chk("rst err", {30'd0, err1, err3}, 32'd0);
    chk("rst d_out L1", d_out1, 32'd0);
    chk("rst d_out L3", d_out3, 32'd0);
    rst_n = 1'b1;

    // Give the modelled window known contents.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'd0;
    for (int r = 0; r < 4; r++) xact(1'b1, START + 32'(64 * r), 3'd5, 1'b0);

    tbl[0]  = '{1'b0, START,           3'd2, 32'h0,         32'h00000000};
    tbl[1]  = '{1'b1, START + 32'd1,   3'd0, 32'h123456AB,  32'h0};
    tbl[2]  = '{1'b0, START,           3'd2, 32'h0,         32'h00AB0000};
    tbl[3]  = '{1'b0, START + 32'd1,   3'd0, 32'h0,         32'h000000AB};
    tbl[4]  = '{1'b1, START + 32'd6,   3'd1, 32'h1234BEEF,  32'h0};
    tbl[5]  = '{1'b0, START + 32'd4,   3'd2, 32'h0,         32'h0000BEEF};
    tbl[6]  = '{1'b1, START + 32'd7,   3'd1, 32'h0000CAFE,  32'h0};
    tbl[7]  = '{1'b0, START + 32'd7,   3'd1, 32'h0,         32'h0000CAFE};
    tbl[8]  = '{1'b1, START + 32'd9,   3'd2, 32'h11223344,  32'h0};
    tbl[9]  = '{1'b0, START + 32'd11,  3'd0, 32'h0,         32'h00000044};
    tbl[10] = '{1'b0, START + 32'd10,  3'd7, 32'h0,         32'h11223344};
    for (int t = 0; t < 11; t++) begin
      wbuf[0] = tbl[t].w;
      xact(tbl[t].wr, tbl[t].a, tbl[t].sz, 1'b0);
      if (!tbl[t].wr) begin
        chk($sformatf("tbl%0d L1", t), rb[0][0], tbl[t].exp);
        chk($sformatf("tbl%0d L3", t), rb[1][0], tbl[t].exp);
      end
    end

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    xact(1'b1, START + 32'h10, 3'd3, 1'b0);
    xact(1'b0, START + 32'h10, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("burst4 beat%0d", i), rb[1][i], 32'(i + 1));
    xact(1'b0, START + 32'h10, 3'd4, 1'b1);

    // Reset lands on beat 2 of a burst-16 write.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hF0 + 32'(i);
    enable = 1'b1; wren = 1'b1; addr = START + 32'h40; acc_size = 3'd5; d_in = wbuf[0];
    tick();
    enable = 1'b0; d_in = wbuf[1];
    tick();
    rst_n = 1'b0; d_in = wbuf[2];
    tick();
    chk("midrst busy", {30'd0, busy1, busy3}, 32'd0);
    chk("midrst d_valid", {30'd0, d_valid1, d_valid3}, 32'd0);
    chk("midrst d_out", d_out1 | d_out3, 32'd0);
    rst_n = 1'b1;
    lastd[0] = '0; lastd[1] = '0;
    model_write(8'h40, 3'd2, 2);
    xact(1'b0, START + 32'h40, 3'd5, 1'b0);
    chk("midrst w0", rb[0][0], 32'hF0);
    chk("midrst w1", rb[0][1], 32'hF1);
    chk("midrst w2", rb[0][2], 32'h0);

    for (int r = 0; r < 40; r++) begin
      bit [2:0] sz = 3'($urandom);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      xact(1'($urandom), START + 32'($urandom_range(0, 191)), sz, 1'($urandom));
    end

`ifdef MAIN_MEM_ADDR_CHECK_EN
    enable = 1'b1; wren = 1'b0; addr = 32'h80000000; acc_size = 3'd2;
    tick();
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) chk("oob L1", {d_valid1, err1, d_out1[29:0]}, 32'hC0000000);
      if (k == 3) chk("oob L3", {d_valid3, err3, d_out3[29:0]}, 32'hC0000000);
    end
    chk("oob err held", {30'd0, err1, err3}, 32'd3);
    lastd[0] = '0; lastd[1] = '0;
    xact(1'b0, START, 3'd2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
